// File: rtl/lfsr_seq_ctrl_pkg.sv
// Shared types and constants for the PRBS sequencing controller.
package lfsr_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, WARM, GEN, HOLD} state_e;

  localparam int LFSR_LEN = 31;
  localparam logic [LFSR_LEN-1:0] ZERO_SEED_SUB = 31'h0000_0001;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Seed and keystream-word handshakes between the control logic and the sequencer.
interface lfsr_seq_ctrl_if
  import lfsr_ctrl_pkg::*;
#(
  parameter int WORD_W = 8
);
  logic                seed_valid;
  logic                seed_ready;
  logic [LFSR_LEN-1:0] seed_data;
  logic                word_valid;
  logic                word_ready;
  logic [WORD_W-1:0]   word_data;

  // master = seed producer / word consumer, slave = the sequencer
  modport master (output seed_valid, seed_data, word_ready,
                  input  seed_ready, word_valid, word_data);
  modport slave  (input  seed_valid, seed_data, word_ready,
                  output seed_ready, word_valid, word_data);
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// Seeds the external PRBS register serially, discards WARMUP bits, then
// streams WORD_W-bit keystream words with one HOLD cycle per word.
module lfsr_seq_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int WARMUP = 0
) (
  input  logic             clk,
  input  logic             reset,
  lfsr_seq_ctrl_if.slave   bus,
  output logic             busy,
  output logic             lfsr_load,
  output logic             lfsr_load_it,
  output logic             lfsr_enable,
  input  logic             lfsr_bit
);

  localparam int CNT_W = $clog2(max3(LFSR_LEN, WORD_W, WARMUP) + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LFSR_LEN-1:0] shadow_q;
  logic [WORD_W-1:0]   word_q;
  logic [IDX_W-1:0]    bit_idx;
  logic                seed_rdy;
  logic                seed_hs;

  assign seed_rdy = (state_q == IDLE) || (state_q == HOLD);
  assign seed_hs  = bus.seed_valid & seed_rdy;
  // counter runs WORD_W-1..0 in GEN, so the first sample lands in bit 0
  assign bit_idx  = IDX_W'(WORD_W - 1) - IDX_W'(cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (seed_hs) begin
        state_d = LOAD;
        cnt_d   = CNT_W'(LFSR_LEN - 1);
      end
      LOAD: begin
        if (cnt_q == '0) begin
          if (WARMUP > 0) begin
            state_d = WARM;
            cnt_d   = CNT_W'(WARMUP - 1);
          end else begin
            state_d = GEN;
            cnt_d   = CNT_W'(WORD_W - 1);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WARM: begin
        if (cnt_q == '0) begin
          state_d = GEN;
          cnt_d   = CNT_W'(WORD_W - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GEN: begin
        if (cnt_q == '0) state_d = HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      HOLD: begin
        // a reseed wins over a word handshake; the pending word is dropped
        if (seed_hs) begin
          state_d = LOAD;
          cnt_d   = CNT_W'(LFSR_LEN - 1);
        end else if (bus.word_ready) begin
          state_d = GEN;
          cnt_d   = CNT_W'(WORD_W - 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.seed_ready = seed_rdy;
    bus.word_valid = (state_q == HOLD);
    busy           = (state_q == LOAD) || (state_q == WARM) || (state_q == GEN);
    lfsr_enable    = busy;
    lfsr_load_it   = (state_q == LOAD);
    lfsr_load      = (state_q == LOAD) & shadow_q[0];
  end

  assign bus.word_data = word_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      word_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (seed_hs)
        shadow_q <= (bus.seed_data == '0) ? ZERO_SEED_SUB : bus.seed_data;
      else if (state_q == LOAD)
        shadow_q <= shadow_q >> 1;
      if (state_q == GEN)
        word_q[bit_idx] <= lfsr_bit;
    end
  end

endmodule
